sw_input_debouncer: RTL and testbench



---
 rtl/sw_input_pkg.sv | 15 +
 rtl/debounce_bit.sv | 50 +++++
 rtl/sw_input_debouncer.sv | 79 +++++++
 tb/tb_sw_input_debouncer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_input_pkg.sv
// sw_input_pkg: shared constants for the board switch/button reader.
// Defaults target a 100 MHz clock with a 1 ms sample tick.
package sw_input_pkg;

  localparam int SW_WIDTH          = 16;
  localparam int SW_TICK_DIV       = 100000;
  localparam int SW_STABLE_SAMPLES = 8;
  localparam int SW_STEP_BIT       = 15;

  // prescaler counter width, never below one bit
  function automatic int cnt_w(input int div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: per-bit sample history and level acceptance.
// Emits a one-cycle rise/fall pulse when a new level is accepted.
module debounce_bit
  import sw_input_pkg::*;
#(
  parameter int SAMPLES = SW_STABLE_SAMPLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic din,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic pulse_nxt
);

  // only the newest SAMPLES-1 samples are kept; the oldest one
  // would be shifted out before it could ever be looked at
  logic [SAMPLES-2:0] hist;
  logic [SAMPLES-1:0] win;
  logic               rise_nxt;
  logic               fall_nxt;

  // window = stored history plus the sample entering at this tick
  always_comb begin
    win      = {hist, din};
    rise_nxt = tick & (&win) & ~stable;
    fall_nxt = tick & ~(|win) & stable;
  end

  assign pulse_nxt = rise_nxt | fall_nxt;

  // history shift on tick, level update and single-cycle pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist   <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      if (tick) hist <= win[SAMPLES-2:0];
      rise <= rise_nxt;
      fall <= fall_nxt;
      if (rise_nxt)      stable <= 1'b1;
      else if (fall_nxt) stable <= 1'b0;
    end
  end

endmodule

// File: rtl/sw_input_debouncer.sv
// sw_input_debouncer: sync, debounce and edge-detect board inputs.
// Define STEP_PULSE_EN to add the single-step enable output.
module sw_input_debouncer
  import sw_input_pkg::*;
#(
  parameter int WIDTH          = SW_WIDTH,
  parameter int TICK_DIV       = SW_TICK_DIV,
  parameter int STABLE_SAMPLES = SW_STABLE_SAMPLES,
  parameter int STEP_BIT       = SW_STEP_BIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
`ifdef STEP_PULSE_EN
  ,
  output logic             step_pulse
`endif
);

  localparam int CNT_W = cnt_w(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  if (TICK_DIV < 2 || STABLE_SAMPLES < 2 ||
      STEP_BIT >= WIDTH) begin : g_bad_cfg
    $error("sw_input_debouncer: bad parameters");
  end

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] pulse_nxt;

  assign tick = (cnt == CNT_LAST);

  // free-running sample prescaler, wraps at TICK_DIV-1
  always_ff @(posedge clk) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CNT_W'(1);
  end

  // two-flop synchroniser plus the registered change flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1      <= '0;
      sync2      <= '0;
      sw_changed <= 1'b0;
    end else begin
      sync1      <= sw_raw;
      sync2      <= sync1;
      sw_changed <= |pulse_nxt;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SAMPLES(STABLE_SAMPLES)
    ) u_bit (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .din      (sync2[i]),
      .stable   (sw_stable[i]),
      .rise     (sw_rise[i]),
      .fall     (sw_fall[i]),
      .pulse_nxt(pulse_nxt[i])
    );
  end

`ifdef STEP_PULSE_EN
  assign step_pulse = sw_rise[STEP_BIT];
`endif

endmodule

// File: tb/tb_sw_input_debouncer.sv
// tb_sw_input_debouncer: scoreboard bench for sw_input_debouncer.
// Expected pulses are queued at stimulus time, checked at negedge.
module tb_sw_input_debouncer;

  localparam int W  = 16;
  localparam int TD = 4;
  localparam int SS = 3;

  typedef struct {
    int           cyc;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_stable;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;
  logic         sw_changed;
`ifdef STEP_PULSE_EN
  logic         step_pulse;
`endif

  sw_input_debouncer #(
    .WIDTH(W),
    .TICK_DIV(TD),
    .STABLE_SAMPLES(SS),
    .STEP_BIT(15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw_raw    (sw_raw),
    .sw_stable (sw_stable),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_changed(sw_changed)
`ifdef STEP_PULSE_EN
    ,
    .step_pulse(step_pulse)
`endif
  );

  always #5 clk = ~clk;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  ph = 0;
  int  ticks = 0;
  int  rise_cnt[W];
  int  fall_cnt[W];
  int  rise_cyc[W];
  ev_t sb_q[$];
  ev_t mon_ev;
  bit  sb_en = 1'b1;

  // bench-side edge counter and prescaler phase model
  always @(posedge clk) begin
    if (rst_n && ph == TD - 1) ticks <= ticks + 1;
    ph  <= !rst_n ? 0 : (ph + 1) % TD;
    cyc <= cyc + 1;
  end

  // monitor: pulse bookkeeping and scoreboard comparison
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < W; i++) begin
        if (sw_rise[i]) begin
          rise_cnt[i]++;
          rise_cyc[i] = cyc;
        end
        if (sw_fall[i]) fall_cnt[i]++;
      end
      total++;
      if (sw_changed !== |(sw_rise | sw_fall)) begin
        bad++;
        $display("FAIL changed_or @%0d: got %b rise %h fall %h",
                 cyc, sw_changed, sw_rise, sw_fall);
      end
      if (sb_en) begin
        if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
          total++;
          bad++;
          $display("FAIL missed_pulse @%0d: want rise %h fall %h at %0d",
                   cyc, sb_q[0].rise, sb_q[0].fall, sb_q[0].cyc);
          void'(sb_q.pop_front());
        end
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
          mon_ev = sb_q.pop_front();
          total++;
          if (sw_rise !== mon_ev.rise) begin
            bad++;
            $display("FAIL sb_rise @%0d: got %h want %h",
                     cyc, sw_rise, mon_ev.rise);
          end
          total++;
          if (sw_fall !== mon_ev.fall) begin
            bad++;
            $display("FAIL sb_fall @%0d: got %h want %h",
                     cyc, sw_fall, mon_ev.fall);
          end
          total++;
          if (sw_changed !== 1'b1) begin
            bad++;
            $display("FAIL sb_changed @%0d: got %b want 1",
                     cyc, sw_changed);
          end
`ifdef STEP_PULSE_EN
          total++;
          if (step_pulse !== mon_ev.rise[15]) begin
            bad++;
            $display("FAIL sb_step @%0d: got %b want %b",
                     cyc, step_pulse, mon_ev.rise[15]);
          end
`endif
        end else if ((sw_rise | sw_fall) !== '0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse @%0d: rise %h fall %h",
                   cyc, sw_rise, sw_fall);
        end
      end
    end
  end

  // edge at which a clean step driven after edge c is accepted
  function automatic int accept_cyc(input int c, input int p);
    int j = 3;
    while ((p + j - 1) % TD != TD - 1) j++;
    return c + j + (SS - 1) * TD;
  endfunction

  task automatic push(input logic [W-1:0] r, input logic [W-1:0] f);
    ev_t e;
    e.cyc  = accept_cyc(cyc, ph);
    e.rise = r;
    e.fall = f;
    sb_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb_q.size() > 0 && n < 80) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (sb_q.size() > 0) begin
      bad++;
      $display("FAIL %s_timeout: got %0d pending want 0",
               name, sb_q.size());
      sb_q.delete();
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    sw_raw = '1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({sw_stable, sw_rise, sw_fall, sw_changed} !== '0) begin
        bad++;
        $display("FAIL reset_out: got st %h r %h f %h c %b want 0",
                 sw_stable, sw_rise, sw_fall, sw_changed);
      end
`ifdef STEP_PULSE_EN
      total++;
      if (step_pulse !== 1'b0) begin
        bad++;
        $display("FAIL reset_step: got %b want 0", step_pulse);
      end
`endif
    end
    sw_raw = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (sw_stable !== '0) begin
      bad++;
      $display("FAIL reset_after: got %h want 0", sw_stable);
    end
  endtask

  task automatic test_step();
    for (int p = 0; p < TD; p++) begin
      int c, n, lat, r0;
      n = 0;
      while (ph != p && n < 10) begin
        @(posedge clk);
        #1;
        n++;
      end
      c  = cyc;
      r0 = rise_cnt[0];
      sw_raw[0] = 1'b1;
      push(16'h0001, 16'h0000);
      drain("step_rise");
      total++;
      if (sw_stable[0] !== 1'b1) begin
        bad++;
        $display("FAIL step_stable p%0d: got %b want 1", p, sw_stable[0]);
      end
      lat = rise_cyc[0] - (c + 1);
      total++;
      if (lat < 10 || lat > 13) begin
        bad++;
        $display("FAIL step_latency p%0d: got %0d want 10..13", p, lat);
      end
      total++;
      if (rise_cnt[0] - r0 != 1) begin
        bad++;
        $display("FAIL step_count p%0d: got %0d want 1",
                 p, rise_cnt[0] - r0);
      end
      sw_raw[0] = 1'b0;
      push(16'h0000, 16'h0001);
      drain("step_fall");
    end
  endtask

  task automatic test_bounce();
    int r0, f0, c, n, lat;
    sb_en = 1'b0;
    r0 = rise_cnt[3];
    f0 = fall_cnt[3];
    for (int i = 0; i < 14; i++) begin
      sw_raw[3] = ~sw_raw[3];
      repeat (3) @(posedge clk);
      #1;
    end
    total++;
    if (rise_cnt[3] != r0 || fall_cnt[3] != f0) begin
      bad++;
      $display("FAIL bounce_quiet: got r%0d f%0d want 0 0",
               rise_cnt[3] - r0, fall_cnt[3] - f0);
    end
    c = cyc;
    sw_raw[3] = 1'b1;
    n = 0;
    while (rise_cnt[3] == r0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    lat = rise_cyc[3] - (c + 1);
    total++;
    if (rise_cnt[3] != r0 + 1 || lat > 13) begin
      bad++;
      $display("FAIL bounce_rise: got n%0d lat %0d want 1 <=13",
               rise_cnt[3] - r0, lat);
    end
    repeat (20) @(posedge clk);
    #1;
    total++;
    if (rise_cnt[3] != r0 + 1 || sw_stable[3] !== 1'b1) begin
      bad++;
      $display("FAIL bounce_hold: got n%0d st %b want 1 1",
               rise_cnt[3] - r0, sw_stable[3]);
    end
    sb_en = 1'b1;
    sw_raw[3] = 1'b0;
    push(16'h0000, 16'h0008);
    drain("bounce_fall");
  endtask

  task automatic test_glitch();
    int f0;
    sw_raw[5] = 1'b1;
    push(16'h0020, 16'h0000);
    drain("glitch_up");
    f0 = fall_cnt[5];
    sw_raw[5] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    sw_raw[5] = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    total++;
    if (sw_stable[5] !== 1'b1 || fall_cnt[5] != f0) begin
      bad++;
      $display("FAIL glitch: got st %b falls %0d want 1 0",
               sw_stable[5], fall_cnt[5] - f0);
    end
    sw_raw[5] = 1'b0;
    push(16'h0000, 16'h0020);
    drain("glitch_down");
  endtask

  task automatic test_simultaneous();
    sw_raw = 16'h8001;
    push(16'h8001, 16'h0000);
    drain("simul_rise");
    total++;
    if (sw_stable !== 16'h8001) begin
      bad++;
      $display("FAIL simul_stable: got %h want 8001", sw_stable);
    end
    sw_raw = 16'h0000;
    push(16'h0000, 16'h8001);
    drain("simul_fall");
  endtask

  task automatic test_reset_mid();
    int t0, r0, n, c, lat;
    t0 = ticks;
    r0 = rise_cnt[2];
    sw_raw[2] = 1'b1;
    n = 0;
    while (ticks - t0 < 2 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (rise_cnt[2] != r0 ||
        {sw_stable, sw_rise, sw_fall, sw_changed} !== '0) begin
      bad++;
      $display("FAIL midrst_clear: got n%0d st %h want 0 0",
               rise_cnt[2] - r0, sw_stable);
    end
    rst_n = 1'b1;
    c = cyc;
    push(16'h0004, 16'h0000);
    drain("midrst_rise");
    lat = rise_cyc[2] - (c + 1);
    total++;
    if (rise_cnt[2] != r0 + 1 || lat < 10 || lat > 13) begin
      bad++;
      $display("FAIL midrst_latency: got n%0d lat %0d want 1 10..13",
               rise_cnt[2] - r0, lat);
    end
    sw_raw[2] = 1'b0;
    push(16'h0000, 16'h0004);
    drain("midrst_fall");
  endtask

  initial begin
    test_reset();
    test_step();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
